// File: rtl/soc_system_sysid_ext.sv
// soc_system_sysid_ext: Avalon-MM system ID block with scratch register and optional uptime/seconds counters.
// Define SYSID_UPTIME_EN to build the uptime counter, HI shadow, prescaler, SECONDS and CTRL.
module soc_system_sysid_ext #(
  parameter logic [31:0] ID_VALUE     = 32'hA5A5_0001,
  parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
  parameter int unsigned CLK_FREQ_HZ  = 50000000,
  parameter logic [31:0] SCRATCH_INIT = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        readdatavalid,
  output logic        waitrequest
);
  logic [31:0] scratch;
  logic [31:0] rmux;
  assign waitrequest = 1'b0;
`ifdef SYSID_UPTIME_EN
  logic [63:0] uptime;
  logic [31:0] up_hi;
  logic [31:0] presc;
  logic [31:0] seconds;
  logic        freeze;
  logic        ctrl_wr;
  logic        clr;
  assign ctrl_wr = write && address == 3'd6;
  assign clr     = ctrl_wr && writedata[0];
  // Clear takes priority over counting and over the shadow capture on the same edge.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      uptime  <= '0;
      up_hi   <= '0;
      presc   <= '0;
      seconds <= '0;
      freeze  <= 1'b0;
    end else begin
      if (clr) begin
        uptime  <= '0;
        up_hi   <= '0;
        presc   <= '0;
        seconds <= '0;
      end else begin
        if (!freeze) begin
          uptime  <= uptime + 64'd1;
          presc   <= (presc == CLK_FREQ_HZ - 1) ? '0 : presc + 32'd1;
          seconds <= (presc == CLK_FREQ_HZ - 1) ? seconds + 32'd1 : seconds;
        end
        if (read && address == 3'd2) up_hi <= uptime[63:32];
      end
      if (ctrl_wr) freeze <= writedata[1];
    end
`endif
  always_comb begin
    rmux = '0;
    case (address)
      3'd0: rmux = ID_VALUE;
      3'd1: rmux = TIMESTAMP;
      3'd5: rmux = scratch;
`ifdef SYSID_UPTIME_EN
      3'd2: rmux = uptime[31:0];
      3'd3: rmux = up_hi;
      3'd4: rmux = seconds;
      3'd6: rmux = {30'b0, freeze, 1'b0};
      3'd7: rmux = 32'd1;
`endif
      default: rmux = '0;
    endcase
  end
  // The mux sees pre-write state, so a simultaneous read returns the old value.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
      scratch       <= SCRATCH_INIT;
    end else begin
      readdatavalid <= read;
      if (read) readdata <= rmux;
      if (write && address == 3'd5) scratch <= writedata;
    end
endmodule

// File: tb/tb_soc_system_sysid_ext.sv
// tb_soc_system_sysid_ext: table-driven scoreboard bench for soc_system_sysid_ext.
module tb_soc_system_sysid_ext;
  localparam logic [31:0] ID = 32'hA5A5_0001;
  localparam logic [31:0] TS = 32'h0000_0000;
  localparam logic [31:0] SI = 32'h5A5A_0000;
`ifdef SYSID_UPTIME_EN
  localparam logic [31:0] CAPS = 32'd1;
`else
  localparam logic [31:0] CAPS = 32'd0;
`endif
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        waitrequest;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] q[$];
  logic [31:0] last = '0;
  typedef struct {
    logic [2:0]  a;
    logic        rd;
    logic        wr;
    logic [31:0] wd;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vecs[$];

  soc_system_sysid_ext #(
    .ID_VALUE(ID), .TIMESTAMP(TS), .CLK_FREQ_HZ(4), .SCRATCH_INIT(SI)
  ) dut (
    .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .readdatavalid(readdatavalid),
    .waitrequest(waitrequest)
  );

  always #5 clock = ~clock;

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic vec_t rv(input logic [2:0] a, input logic [31:0] exp);
    vec_t v = '{a, 1'b1, 1'b0, 32'd0, exp, $sformatf("read%0d", a)};
    return v;
  endfunction

  function automatic vec_t wv(input logic [2:0] a, input logic [31:0] wd);
    vec_t v = '{a, 1'b0, 1'b1, wd, 32'd0, $sformatf("write%0d", a)};
    return v;
  endfunction

  // Drive at negedge, push expectation, sample 1ns after the edge, return at next negedge.
  task automatic acc(input vec_t v);
    address = v.a; read = v.rd; write = v.wr; writedata = v.wd;
    if (v.rd) q.push_back(v.exp);
    @(posedge clock);
    #1;
    read = 1'b0; write = 1'b0;
    check({v.name, " valid"}, 32'(readdatavalid), 32'(v.rd));
    if (readdatavalid) begin
      last = (q.size() != 0) ? q.pop_front() : 32'hxxxx_xxxx;
      check(v.name, readdata, last);
    end
    @(negedge clock);
  endtask

  initial begin
    vec_t rw;
    vecs.push_back(rv(0, ID));
    vecs.push_back(rv(1, TS));
    vecs.push_back(rv(5, SI));
    vecs.push_back(rv(7, CAPS));
    vecs.push_back(wv(5, 32'hDEAD_BEEF));
    vecs.push_back(wv(0, 32'h0000_1234));
    vecs.push_back(wv(1, 32'hFFFF_FFFF));
    vecs.push_back(wv(7, 32'h0000_0000));
    vecs.push_back(rv(5, 32'hDEAD_BEEF));
    vecs.push_back(rv(0, ID));
    vecs.push_back(rv(1, TS));
    vecs.push_back(rv(7, CAPS));
    rw = '{3'd5, 1'b1, 1'b1, 32'h0000_CAFE, 32'hDEAD_BEEF, "rdwr5"};
    vecs.push_back(rw);
    vecs.push_back(rv(5, 32'h0000_CAFE));
`ifndef SYSID_UPTIME_EN
    vecs.push_back(rv(2, 0));
    vecs.push_back(rv(3, 0));
    vecs.push_back(rv(4, 0));
    vecs.push_back(rv(6, 0));
    vecs.push_back(wv(6, 32'd1));
    vecs.push_back(rv(6, 0));
    vecs.push_back(wv(6, 32'd3));
    vecs.push_back(rv(6, 0));
    vecs.push_back(rv(2, 0));
`endif
    @(posedge clock); @(posedge clock); #1;
    check("reset readdata", readdata, 32'd0);
    check("reset valid", 32'(readdatavalid), 32'd0);
    @(negedge clock);
    reset = 1'b0;
`ifdef SYSID_UPTIME_EN
    repeat (9) @(posedge clock);
    @(negedge clock);
    acc(rv(4, 32'd2));
`endif
    foreach (vecs[i]) acc(vecs[i]);
    @(posedge clock); #1;
    check("idle valid", 32'(readdatavalid), 32'd0);
    check("idle hold", readdata, last);
    @(negedge clock);
`ifdef SYSID_UPTIME_EN
    acc(wv(6, 32'd2));
    force dut.uptime = 64'h0000_0007_FFFF_FFF0;
    #1 release dut.uptime;
    repeat (20) @(negedge clock);
    acc(rv(2, 32'hFFFF_FFF0));
    acc(rv(2, 32'hFFFF_FFF0));
    acc(rv(3, 32'd7));
    acc(wv(6, 32'd3));
    acc(rv(2, 32'd0));
    acc(rv(6, 32'd2));
    acc(rv(3, 32'd0));
    acc(wv(6, 32'd0));
    force dut.uptime = 64'h0000_0000_FFFF_FFFF;
    #1 release dut.uptime;
    @(negedge clock);
    acc(rv(2, 32'd0));
    acc(rv(3, 32'd1));
`endif
    address = 3'd0; read = 1'b1;
    #2 reset = 1'b1;
    @(posedge clock); #1;
    check("rst outstanding valid", 32'(readdatavalid), 32'd0);
    check("rst outstanding data", readdata, 32'd0);
    read = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clock); #1;
      check("post reset valid", 32'(readdatavalid), 32'd0);
    end
    @(negedge clock);
    acc(rv(6, 32'd0));
    acc(rv(5, SI));
    check("scoreboard drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
